// File: rtl/trng_pkg.sv
// Shared constants and types for the TRNG consumer path.
package trng_pkg;

    localparam int unsigned TRNG_WORD_W     = 8;
    localparam int unsigned TRNG_FIFO_DEPTH = 4;
    localparam int unsigned TRNG_RCT_LIMIT  = 16;

    typedef logic [TRNG_WORD_W-1:0] trng_word_t;

endpackage

// File: rtl/trng_word_fifo.sv
// Synchronous word FIFO. Storage is registered and the head is read straight from it.
// Pointers carry an extra wrap bit so that full and empty can be told apart.
module trng_word_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] used;
    logic             do_push;
    logic             do_pop;

    assign used    = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign level_o = LVL_W'(used);

    // Head reads as zero while empty so o_data is clean after reset and drain.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];

    // A pop frees a slot in the same cycle, so a push at full still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Word storage; not reset, since the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/trng_word_packer.sv
// TRNG raw-bit consumer: repetition-count health test, LSB-first word packing,
// and a small output FIFO on a valid/ready interface with sticky error flags.
module trng_word_packer
    import trng_pkg::*;
#(
    parameter int unsigned WORD_W    = TRNG_WORD_W,
    parameter int unsigned DEPTH     = TRNG_FIFO_DEPTH,
    parameter int unsigned RCT_LIMIT = TRNG_RCT_LIMIT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic                       i_bit,
    input  logic                       i_clear,
    output logic [WORD_W-1:0]          o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_overflow,
    output logic                       o_health_fail
);

    localparam int unsigned CNT_W = $clog2(WORD_W);
    localparam int unsigned RUN_W = $clog2(RCT_LIMIT + 1);

    logic [CNT_W-1:0]  bit_cnt_q;
    logic [RUN_W-1:0]  run_q;
    logic              last_bit_q;
    logic [WORD_W-1:0] partial_q;
    logic              overflow_q;
    logic              health_fail_q;

    logic              bit_in;
    logic [RUN_W-1:0]  run_next;
    logic              trip;
    logic              accept;
    logic [WORD_W-1:0] word_next;
    logic              word_done;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;

    assign pop           = o_valid && i_ready;
    assign o_valid       = !fifo_empty;
    assign o_overflow    = overflow_q;
    assign o_health_fail = health_fail_q;

    // Run-length update, RCT trip detection and partial-word assembly.
    always_comb begin
        bit_in = i_valid && !i_clear && !health_fail_q;
        if ((run_q != '0) && (i_bit == last_bit_q)) begin
            run_next = (run_q == RUN_W'(RCT_LIMIT)) ? run_q : run_q + RUN_W'(1);
        end else begin
            run_next = RUN_W'(1);
        end
        trip               = bit_in && (run_next == RUN_W'(RCT_LIMIT));
        accept             = bit_in && !trip;
        word_next          = partial_q;
        word_next[bit_cnt_q] = i_bit;
        word_done          = accept && (bit_cnt_q == CNT_W'(WORD_W - 1));
    end

    // Packer, run counter and sticky flags; clear resets the same state as reset.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            bit_cnt_q     <= '0;
            run_q         <= '0;
            last_bit_q    <= 1'b0;
            partial_q     <= '0;
            overflow_q    <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            if (bit_in) begin
                run_q      <= run_next;
                last_bit_q <= i_bit;
            end
            if (trip) begin
                // Tripping bit and the word in progress are both thrown away.
                health_fail_q <= 1'b1;
                bit_cnt_q     <= '0;
                partial_q     <= '0;
            end else if (word_done) begin
                bit_cnt_q <= '0;
                partial_q <= '0;
            end else if (accept) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                partial_q <= word_next;
            end
            if (word_done && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    trng_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (word_done),
        .push_data_i (word_next),
        .pop_i       (pop),
        .head_o      (o_data),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .level_o     (o_level)
    );

endmodule

// File: tb/tb_trng_word_packer.sv
// Bench for trng_word_packer: directed scenarios plus randomized traffic against a
// queue-based behavioural model.
module tb_trng_word_packer;
    import trng_pkg::*;

    localparam int W = TRNG_WORD_W;
    localparam int D = TRNG_FIFO_DEPTH;
    localparam int L = TRNG_RCT_LIMIT;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     i_valid;
    logic                     i_bit;
    logic                     i_clear;
    logic                     i_ready;
    trng_word_t               o_data;
    logic                     o_valid;
    logic [$clog2(D+1)-1:0]   o_level;
    logic                     o_overflow;
    logic                     o_health_fail;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state.
    trng_word_t m_q[$];
    trng_word_t m_part;
    int         m_cnt;
    int         m_run;
    logic       m_last;
    logic       m_ovf;
    logic       m_hf;

    trng_word_packer #(
        .WORD_W    (W),
        .DEPTH     (D),
        .RCT_LIMIT (L)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_bit         (i_bit),
        .i_clear       (i_clear),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_level       (o_level),
        .o_overflow    (o_overflow),
        .o_health_fail (o_health_fail)
    );

    always #5 clk = ~clk;

    function automatic trng_word_t m_head();
        if (m_q.size() == 0) return '0;
        return m_q[0];
    endfunction

    task automatic model_step(input logic r, input logic v, input logic b, input logic c,
                              input logic y);
        logic       pop;
        logic       push;
        trng_word_t word;
        if (r) begin
            m_q.delete();
            m_part = '0; m_cnt = 0; m_run = 0; m_last = 1'b0; m_ovf = 1'b0; m_hf = 1'b0;
            return;
        end
        pop  = (m_q.size() != 0) && y;
        push = 1'b0;
        word = '0;
        if (c) begin
            m_part = '0; m_cnt = 0; m_run = 0; m_ovf = 1'b0; m_hf = 1'b0;
        end else if (v && !m_hf) begin
            m_run  = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
            if (m_run > L) m_run = L;
            m_last = b;
            if (m_run == L) begin
                m_hf = 1'b1; m_part = '0; m_cnt = 0;
            end else begin
                m_part[m_cnt] = b;
                m_cnt++;
                if (m_cnt == W) begin
                    push = 1'b1; word = m_part; m_part = '0; m_cnt = 0;
                end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < D) m_q.push_back(word);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic b, input logic c,
                         input logic y);
        rst = r; i_valid = v; i_bit = b; i_clear = c; i_ready = y;
        model_step(r, v, b, c, y);
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input trng_word_t w, input logic y);
        for (int i = 0; i < W; i++) drive(1'b0, 1'b1, w[i], 1'b0, y);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_valid); else n_pass++;
        n_checks++; if (int'(o_level) !== 0) $display("FAIL reset_level got %0d want 0", o_level); else n_pass++;
        n_checks++; if (o_data !== 8'h00) $display("FAIL reset_data got %h want 00", o_data); else n_pass++;
        n_checks++; if (o_overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", o_overflow); else n_pass++;
        n_checks++; if (o_health_fail !== 1'b0) $display("FAIL reset_hf got %b want 0", o_health_fail); else n_pass++;
    endtask

    task automatic test_pack();
        logic [7:0] bits;
        do_reset(1);
        bits = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, bits[i], 1'b0, 1'b0);
            if (i == 6) begin
                n_checks++; if (o_valid !== 1'b0) $display("FAIL pack_early_valid got %b want 0", o_valid); else n_pass++;
            end
        end
        n_checks++; if (o_valid !== 1'b1) $display("FAIL pack_valid got %b want 1", o_valid); else n_pass++;
        n_checks++; if (o_data !== 8'h4D) $display("FAIL pack_data got %h want 4d", o_data); else n_pass++;
        n_checks++; if (int'(o_level) !== 1) $display("FAIL pack_level got %0d want 1", o_level); else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (o_data !== 8'h4D) $display("FAIL pack_hold got %h want 4d", o_data); else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (int'(o_level) !== 0) $display("FAIL pack_pop_level got %0d want 0", o_level); else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset(1);
        for (int i = 1; i <= 5; i++) begin
            send_word(trng_word_t'(i), 1'b0);
            if (i == 4) begin
                n_checks++; if (o_overflow !== 1'b0) $display("FAIL ovf_early got %b want 0", o_overflow); else n_pass++;
            end
        end
        n_checks++; if (int'(o_level) !== 4) $display("FAIL ovf_level got %0d want 4", o_level); else n_pass++;
        n_checks++; if (o_overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", o_overflow); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== trng_word_t'(i))
                $display("FAIL ovf_read%0d got v=%b d=%h want v=1 d=%h", i, o_valid, o_data, i[7:0]);
            else n_pass++;
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        n_checks++; if (o_valid !== 1'b0) $display("FAIL ovf_drained got %b want 0", o_valid); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        trng_word_t w;
        logic [7:0] exp [5];
        do_reset(1);
        for (int i = 1; i <= 4; i++) send_word(trng_word_t'(i), 1'b0);
        w = 8'h06;
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, w[i], 1'b0, 1'b0);
        drive(1'b0, 1'b1, w[7], 1'b0, 1'b1);
        n_checks++; if (int'(o_level) !== 4) $display("FAIL full_pp_level got %0d want 4", o_level); else n_pass++;
        n_checks++; if (o_overflow !== 1'b0) $display("FAIL full_pp_ovf got %b want 0", o_overflow); else n_pass++;
        exp[0] = 8'h02; exp[1] = 8'h03; exp[2] = 8'h04; exp[3] = 8'h06;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (o_data !== exp[i]) $display("FAIL full_pp_read%0d got %h want %h", i, o_data, exp[i]);
            else n_pass++;
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_health();
        do_reset(1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 14) begin
                n_checks++; if (o_health_fail !== 1'b0) $display("FAIL rct_early got %b want 0", o_health_fail); else n_pass++;
            end
        end
        n_checks++; if (o_health_fail !== 1'b1) $display("FAIL rct_flag got %b want 1", o_health_fail); else n_pass++;
        n_checks++; if (o_data !== 8'hFF) $display("FAIL rct_word got %h want ff", o_data); else n_pass++;
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, i[0], 1'b0, 1'b0);
        n_checks++; if (int'(o_level) !== 1) $display("FAIL rct_blocked got %0d want 1", o_level); else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (o_health_fail !== 1'b0) $display("FAIL rct_clear got %b want 0", o_health_fail); else n_pass++;
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, i[0], 1'b0, 1'b0);
        n_checks++; if (int'(o_level) !== 2) $display("FAIL rct_level got %0d want 2", o_level); else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (o_data !== 8'hAA) $display("FAIL rct_alt got %h want aa", o_data); else n_pass++;
    endtask

    task automatic test_reset_mid_word();
        do_reset(1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset(1);
        send_word(8'h3C, 1'b0);
        n_checks++; if (o_valid !== 1'b1 || o_data !== 8'h3C) $display("FAIL rstmid_data got v=%b d=%h want v=1 d=3c", o_valid, o_data); else n_pass++;
        n_checks++; if (int'(o_level) !== 1) $display("FAIL rstmid_level got %0d want 1", o_level); else n_pass++;
    endtask

    task automatic test_clear_mid_word();
        do_reset(1);
        for (int i = 1; i <= 5; i++) send_word(trng_word_t'(i), 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++; if (o_overflow !== 1'b0 || o_health_fail !== 1'b0) $display("FAIL clr_flags got o=%b h=%b want 0 0", o_overflow, o_health_fail); else n_pass++;
        n_checks++; if (int'(o_level) !== 4) $display("FAIL clr_fifo got %0d want 4", o_level); else n_pass++;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h5A, 1'b0);
        n_checks++; if (o_data !== 8'h5A || int'(o_level) !== 1) $display("FAIL clr_fresh got d=%h l=%0d want 5a 1", o_data, o_level); else n_pass++;
    endtask

    task automatic test_random();
        logic r, v, b, c, y, prev;
        prev = 1'b0;
        do_reset(1);
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 599) == 0);
            v = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 9) != 0) ? prev : ~prev;
            prev = b;
            c = ($urandom_range(0, 79) == 0);
            y = ((n % 400) < 200) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            drive(r, v, b, c, y);
            n_checks++; if (o_valid !== (m_q.size() != 0)) $display("FAIL rnd_valid@%0d got %b want %b", n, o_valid, m_q.size() != 0); else n_pass++;
            n_checks++; if (o_data !== m_head()) $display("FAIL rnd_data@%0d got %h want %h", n, o_data, m_head()); else n_pass++;
            n_checks++; if (int'(o_level) !== m_q.size()) $display("FAIL rnd_level@%0d got %0d want %0d", n, o_level, m_q.size()); else n_pass++;
            n_checks++; if (o_overflow !== m_ovf) $display("FAIL rnd_ovf@%0d got %b want %b", n, o_overflow, m_ovf); else n_pass++;
            n_checks++; if (o_health_fail !== m_hf) $display("FAIL rnd_hf@%0d got %b want %b", n, o_health_fail, m_hf); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_bit = 1'b0; i_clear = 1'b0; i_ready = 1'b0;
        test_reset();
        test_pack();
        test_overflow();
        test_full_push_pop();
        test_health();
        test_reset_mid_word();
        test_clear_mid_word();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
